// File: rtl/aclk_alarm_bank.sv
// Multi-slot BCD alarm bank: validated loads, per-slot enables, edge-detected match, ring/snooze FSM.
// Optional macro ACLK_ALARM_ONESHOT_EN adds per-slot oneshot bits that auto-disable a slot after it rings.
module aclk_alarm_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2,
    parameter int RING_MIN   = 5,
    parameter int SNOOZE_MIN = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_new_a,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [3:0]            new_alarm_ms_hr,
    input  logic [3:0]            new_alarm_ls_hr,
    input  logic [3:0]            new_alarm_ms_min,
    input  logic [3:0]            new_alarm_ls_min,
`ifdef ACLK_ALARM_ONESHOT_EN
    input  logic                  new_oneshot,
    output logic [NUM_ALARMS-1:0] alarm_oneshot,
`endif
    input  logic                  en_set,
    input  logic                  en_clr,
    input  logic [IDX_W-1:0]      rd_idx,
    input  logic [3:0]            current_time_ms_hr,
    input  logic [3:0]            current_time_ls_hr,
    input  logic [3:0]            current_time_ms_min,
    input  logic [3:0]            current_time_ls_min,
    input  logic                  one_minute,
    input  logic                  stop_alarm,
    input  logic                  snooze,
    output logic [3:0]            alarm_time_ms_hr,
    output logic [3:0]            alarm_time_ls_hr,
    output logic [3:0]            alarm_time_ms_min,
    output logic [3:0]            alarm_time_ls_min,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic                  sound_alarm,
    output logic                  snoozing,
    output logic [IDX_W-1:0]      active_slot,
    output logic                  load_err
);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    logic [15:0]           slot_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] en_q, en_d;
    logic [NUM_ALARMS-1:0] match_q, match_d, prev_q, fire;
    logic                  load_err_q, load_err_d;
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]      active_q, active_d, first_fire;
    logic                  to_idle;
    logic                  time_ok, idx_ok, load_ok;
    logic [15:0]           new_time, cur_time, rd_word;

    assign new_time = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
    assign cur_time = {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min};

    assign time_ok = (new_alarm_ms_hr <= 4'd2) && (new_alarm_ls_hr <= 4'd9)
                   && !((new_alarm_ms_hr == 4'd2) && (new_alarm_ls_hr > 4'd3))
                   && (new_alarm_ms_min <= 4'd5) && (new_alarm_ls_min <= 4'd9);
    assign idx_ok     = int'(load_idx) < NUM_ALARMS;
    assign load_ok    = load_new_a && time_ok && idx_ok;
    assign load_err_d = load_new_a && !(time_ok && idx_ok);

    always_comb begin
        rd_word = 16'h0000;
        if (int'(rd_idx) < NUM_ALARMS) rd_word = slot_q[rd_idx];
    end

    assign {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min} = rd_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) slot_q[i] <= 16'h0000;
        end else if (load_ok) begin
            for (int i = 0; i < NUM_ALARMS; i++)
                if (load_idx == IDX_W'(i)) slot_q[i] <= new_time;
        end
    end

`ifdef ACLK_ALARM_ONESHOT_EN
    logic [NUM_ALARMS-1:0] oneshot_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oneshot_q <= '0;
        end else if (load_ok) begin
            for (int i = 0; i < NUM_ALARMS; i++)
                if (load_idx == IDX_W'(i)) oneshot_q[i] <= new_oneshot;
        end
    end
    assign alarm_oneshot = oneshot_q;
`endif

    // Clear beats set; a oneshot slot also drops its enable when its ring ends.
    always_comb begin
        en_d = en_q;
        if (idx_ok && en_set) en_d[load_idx] = 1'b1;
        if (idx_ok && en_clr) en_d[load_idx] = 1'b0;
`ifdef ACLK_ALARM_ONESHOT_EN
        if (to_idle && oneshot_q[active_q]) en_d[active_q] = 1'b0;
`endif
    end

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++)
            match_d[i] = en_q[i] && (slot_q[i] == cur_time);
    end

    assign fire = match_q & ~prev_q;

    always_comb begin
        first_fire = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (fire[i]) first_fire = IDX_W'(i);
    end

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        to_idle  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|fire) begin
                    state_d  = RING;
                    cnt_d    = 4'd0;
                    active_d = first_fire;
                end
            end
            RING: begin
                if (stop_alarm || !en_q[active_q]) begin
                    to_idle = 1'b1;
                end else if (snooze) begin
                    state_d = SNOOZE;
                    cnt_d   = 4'd0;
                end else if (one_minute) begin
                    if (cnt_inc == 4'(RING_MIN)) to_idle = 1'b1;
                    else cnt_d = cnt_inc;
                end
            end
            SNOOZE: begin
                if (stop_alarm || !en_q[active_q]) begin
                    to_idle = 1'b1;
                end else if (one_minute) begin
                    if (cnt_inc == 4'(SNOOZE_MIN)) begin
                        state_d = RING;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: to_idle = 1'b1;
        endcase
        if (to_idle) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q       <= '0;
            match_q    <= '0;
            prev_q     <= '0;
            load_err_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            active_q   <= '0;
        end else begin
            en_q       <= en_d;
            match_q    <= match_d;
            prev_q     <= match_q;
            load_err_q <= load_err_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
        end
    end

    assign alarm_en    = en_q;
    assign sound_alarm = (state_q == RING);
    assign snoozing    = (state_q == SNOOZE);
    assign active_slot = active_q;
    assign load_err    = load_err_q;

endmodule

// File: doc/aclk_alarm_bank.md
Name: aclk_alarm_bank

Overview:
- Parametrised multi-slot alarm register bank for the alarm clock.
- Holds NUM_ALARMS BCD alarm times with per-slot enable and load-time BCD validation.
- Compares every enabled slot against the current time and runs a ring/snooze/stop state machine.
- Sits between the keypad/FSM load path and the display/speaker logic.

Parameters:
- NUM_ALARMS, 4: number of alarm slots (2..16).
- IDX_W, 2: slot index width; must equal clog2(NUM_ALARMS).
- RING_MIN, 5: minutes of ringing before auto-stop (1..15).
- SNOOZE_MIN, 9: snooze length in minutes (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load_new_a  in  1  write strobe for slot load_idx.
- load_idx  in  IDX_W  slot to write or enable.
- new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min  in  4 each  BCD time to load.
- en_set  in  1  set the enable of slot load_idx.
- en_clr  in  1  clear the enable of slot load_idx.
- rd_idx  in  IDX_W  slot selected for readback.
- current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min  in  4 each  current BCD time.
- one_minute  in  1  single-cycle pulse once per minute.
- stop_alarm  in  1  stop ringing or snoozing.
- snooze  in  1  request snooze.
- alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min  out  4 each  time of slot rd_idx.
- alarm_en  out  NUM_ALARMS  per-slot enable bits.
- sound_alarm  out  1  high while in RING.
- snoozing  out  1  high while in SNOOZE.
- active_slot  out  IDX_W  slot that caused the current ring.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, active-high): all slot times 0, alarm_en 0, FSM IDLE, counter 0, active_slot 0, load_err 0, match history 0.
- Readback: alarm_time_* is a combinational mux of slot rd_idx. rd_idx >= NUM_ALARMS reads 0.
- Load: on a clk edge with load_new_a=1, slot load_idx takes the new value only if the time is valid:
  - ms_hr<=2, ls_hr<=9, and ls_hr<=3 when ms_hr==2;
  - ms_min<=5, ls_min<=9.
  - An invalid value leaves the slot unchanged and pulses load_err for 1 cycle.
  - load_idx >= NUM_ALARMS: write ignored, load_err pulses.
  - Result is visible on readback in the next cycle.
- Enable: en_set sets alarm_en[load_idx]; en_clr clears it. en_set and en_clr together: clear wins. Loading does not change the enable bit.
- Match: match_i = alarm_en[i] AND (slot i == current time, all four digits). Registered per-slot history; fire_i = match_i AND NOT prev_match_i. Enabling or loading a slot during its matching minute therefore fires.
- FSM, one cycle per transition:
  - IDLE: if any fire_i, go to RING; active_slot = lowest firing index; cnt=0.
  - RING: sound_alarm=1. Priority: stop_alarm -> IDLE; else snooze -> SNOOZE with cnt=0; else one_minute increments cnt, and when cnt reaches RING_MIN -> IDLE.
  - SNOOZE: snoozing=1. stop_alarm -> IDLE; one_minute increments cnt, and when cnt reaches SNOOZE_MIN -> RING with cnt=0.
  - In RING or SNOOZE, clearing the enable of active_slot -> IDLE on the next edge.
  - Fires from other slots while in RING or SNOOZE are dropped, not queued. Their history still updates, so they do not re-fire later in the same minute.
- Outputs sound_alarm and snoozing are registered from state: asserted the cycle after the transition edge. Latency from the current-time change to sound_alarm is 2 clocks (history register, then state register).
- active_slot holds its value in IDLE until the next fire.

Optional Feature:
- Macro: ACLK_ALARM_ONESHOT_EN.
- Defined:
  - Adds input new_oneshot (1) and a per-slot oneshot bit, written together with a valid load.
  - When the FSM leaves RING or SNOOZE to IDLE (stop, timeout or disable), alarm_en[active_slot] clears if its oneshot bit is set.
  - Adds output alarm_oneshot (NUM_ALARMS).
- Undefined: port and bits absent; enables persist until en_clr.

Test Plan:
- Reset then readback of all slots -> 00:00, alarm_en=0. Current time 00:00 -> sound_alarm stays 0.
- Load slot2=07:30 and enable it; time steps 07:29 -> 07:30 -> sound_alarm=1 two clocks later, active_slot=2.
- Load 24:00 and 12:60 into slot1 -> each pulses load_err once; slot1 keeps its prior value. Load 23:59 -> accepted.
- Ringing; assert snooze -> snoozing=1. After 9 one_minute pulses -> RING again. Assert stop_alarm and snooze in the same cycle -> IDLE.
- Slots 0 and 3 both set to 06:00 and enabled -> active_slot=0. Ringing with no input for 5 one_minute pulses -> IDLE. Still 06:00 -> no refire.
- ACLK_ALARM_ONESHOT_EN: oneshot slot fires; stop_alarm -> alarm_en bit clears. Same time the next day -> no ring.
